adc_seq_ctrl: RTL and testbench
===============================

// Module: adc_seq_ctrl
// PURPOSE
//  Digital sequencer for the SAR ADC macro. Scans up to NCH input channels,
//  issues one start pulse per conversion, and averages 4^osr_sel samples per channel.
//  Delivers one result per enabled channel over a valid/ready stream to the wishbone/logic-analyzer side.
//  Sits between the user-project register file and the analog ADC macro.
// PARAMETERS
//  NCH       4   number of analog channels; adc_ch_sel width CW = max(1,$clog2(NCH))
//  RES_W     16  ADC raw result width and averaged output width
//  TMO_W     16  width of the conversion-timeout counter/limit
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous reset, active-high
//  enable         in   1      block enable; low aborts and holds IDLE
//  trig           in   1      start one scan (level sampled, acts in IDLE only)
//  continuous     in   1      1 = restart scan automatically after last channel
//  ch_mask        in   NCH    channel enable mask, bit i = channel i
//  osr_sel        in   3      oversampling: samples = 4^osr_sel (0..4), >4 clamps to 4
//  timeout_cycles in   TMO_W  max clk cycles waiting for adc_done (see CONFIGURATION)
//  adc_start      out  1      one-cycle start pulse to ADC macro
//  adc_ch_sel     out  CW     channel currently being converted
//  adc_result     in   RES_W  ADC raw result, stable while adc_done high
//  adc_done       in   1      ADC conversion-finished, asynchronous level
//  res_data       out  RES_W  averaged result
//  res_ch         out  CW     channel of res_data
//  res_valid      out  1      result valid, held until res_ready
//  res_ready      in   1      consumer accepts result
//  busy           out  1      high in any state except IDLE
//  err_timeout    out  1      sticky timeout flag
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, accumulator/counters 0, synchroniser flops 0.
//  - adc_done passes a 2-flop synchroniser, then a rising-edge detect. A done edge is acted on 3 clks after the async rise.
//  - Config (ch_mask, osr_sel, continuous) is latched on IDLE->SCAN. Later changes apply at the next scan.
//  - FSM:
//    - IDLE: if enable & trig & |ch_mask -> latch config, ch = lowest set bit -> START.
//      ch_mask==0: trig ignored, stay IDLE.
//    - START: adc_start=1 for exactly one cycle, adc_ch_sel=ch -> WAIT.
//    - WAIT: on done edge -> acc += adc_result (zero-extended), sample_cnt++ -> ACC.
//    - ACC: if sample_cnt < 4^osr -> START, else -> OUT.
//    - OUT: res_data = acc >> (2*osr) (truncating), res_ch = ch, res_valid = 1.
//      On res_valid & res_ready: clear acc/sample_cnt, ch = next set bit above ch.
//      If none remains: continuous ? first set bit -> START : IDLE.
//  - Accumulator width is RES_W+8, so no overflow is possible (256 x max code).
//  - Backpressure: FSM stalls in OUT, and no adc_start is issued while res_valid is unaccepted.
//  - res_valid deasserts the cycle after the handshake. res_data/res_ch are stable while valid.
//  - trig while busy: ignored. Done edge outside WAIT: ignored, and never counted later.
//  - enable low in any state: next cycle FSM -> IDLE, acc cleared, res_valid cleared (result dropped).
//    err_timeout keeps its value.
//  - rst mid-operation: immediate return to reset state; a pending adc_done edge is discarded.
//  - Throughput at osr_sel=0: one start per (ADC conversion + 3 sync + 3 FSM) cycles.
// CONFIGURATION
//  - ADC_SEQ_TIMEOUT_EN defined:
//    - WAIT counts clks. At count == timeout_cycles (0 = disabled), err_timeout is set (sticky).
//    - The channel is abandoned: acc cleared, no result emitted, advance as after an OUT handshake.
//    - err_timeout clears only on rst or an accepted trig in IDLE.
//  - Not defined: WAIT waits indefinitely. timeout_cycles is ignored and err_timeout is tied 0.
// TESTING
//  1. ch_mask=4'b0101, osr=0, adc_result=16'h3344, trig -> two results (ch0 then ch2), data 16'h3344, busy low after.
//  2. osr=2, results alternate 16'h1122/16'h3344 -> exactly 16 adc_start pulses, then res_data=16'h2233.
//  3. res_ready held low 50 clks in OUT -> no adc_start in that window; data stable; accept -> next channel starts.
//  4. continuous=1, mask=4'b1000, osr=1 -> ch3 results back to back; enable low mid-WAIT -> IDLE next clk, res_valid 0.
//  5. ADC_SEQ_TIMEOUT_EN, timeout_cycles=100, adc_done stuck 0 -> err_timeout at cycle 100 of WAIT, channel skipped.
//  6. rst asserted in WAIT, adc_done rising 1 clk later -> all outputs 0, no result or start until next trig.

Source files
------------

// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: scans SAR ADC channels, averages 4^osr samples per channel, streams results.
// Optional conversion timeout (sticky err_timeout) is compiled in with `define ADC_SEQ_TIMEOUT_EN.
module adc_seq_ctrl #(
    parameter int NCH   = 4,
    parameter int RES_W = 16,
    parameter int TMO_W = 16,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             trig_i,
    input  logic             continuous_i,
    input  logic [NCH-1:0]   ch_mask_i,
    input  logic [2:0]       osr_sel_i,
    input  logic [TMO_W-1:0] timeout_cycles_i,
    output logic             adc_start_o,
    output logic [CW-1:0]    adc_ch_sel_o,
    input  logic [RES_W-1:0] adc_result_i,
    input  logic             adc_done_i,
    output logic [RES_W-1:0] res_data_o,
    output logic [CW-1:0]    res_ch_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             err_timeout_o
);

    localparam int ACC_W = RES_W + 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        ACC,
        OUT
    } SeqState;

    SeqState          state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [NCH-1:0]   chMask_q, chMask_d;
    logic [2:0]       osr_q, osr_d;
    logic             cont_q, cont_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [8:0]       sampleCnt_q, sampleCnt_d;
    logic [RES_W-1:0] resData_q, resData_d;
    logic [CW-1:0]    resCh_q, resCh_d;
    logic             resValid_q, resValid_d;

    logic             sync1_q, sync2_q, doneDly_q;
    logic             doneEdge;

    logic [CW-1:0]    firstLive, firstLatched, nextIdx;
    logic             nextFound;
    logic [3:0]       shamt;
    logic [8:0]       sampleTarget;
    logic             advance;

`ifdef ADC_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] waitCnt_q, waitCnt_d;
    logic             err_q, err_d;
    logic             tmoHit;

    assign tmoHit        = (timeout_cycles_i != '0) &&
                           ((waitCnt_q + TMO_W'(1)) == timeout_cycles_i);
    assign err_timeout_o = err_q;
`else
    logic unusedTmo;

    assign unusedTmo     = ^timeout_cycles_i;
    assign err_timeout_o = 1'b0;
`endif

    // adc_done is asynchronous: two flops to resynchronise, a third to find the rising edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            doneDly_q <= 1'b0;
        end else begin
            sync1_q   <= adc_done_i;
            sync2_q   <= sync1_q;
            doneDly_q <= sync2_q;
        end
    end

    assign doneEdge     = sync2_q & ~doneDly_q;
    assign shamt        = {osr_q, 1'b0};
    assign sampleTarget = 9'd1 << shamt;

    // Descending scan so the lowest qualifying channel is the one left standing
    always_comb begin
        firstLive    = '0;
        firstLatched = '0;
        nextIdx      = '0;
        nextFound    = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                firstLive = CW'(i);
            end
            if (chMask_q[i]) begin
                firstLatched = CW'(i);
            end
            if (chMask_q[i] && (CW'(i) > ch_q)) begin
                nextIdx   = CW'(i);
                nextFound = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        chMask_d    = chMask_q;
        osr_d       = osr_q;
        cont_d      = cont_q;
        acc_d       = acc_q;
        sampleCnt_d = sampleCnt_q;
        resData_d   = resData_q;
        resCh_d     = resCh_q;
        resValid_d  = resValid_q;
        advance     = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
        waitCnt_d   = waitCnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable_i && trig_i && (|ch_mask_i)) begin
                    chMask_d = ch_mask_i;
                    osr_d    = (osr_sel_i > 3'd4) ? 3'd4 : osr_sel_i;
                    cont_d   = continuous_i;
                    ch_d     = firstLive;
                    state_d  = START;
`ifdef ADC_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
            end
            START: begin
                state_d = WAIT;
`ifdef ADC_SEQ_TIMEOUT_EN
                waitCnt_d = '0;
`endif
            end
            WAIT: begin
                if (doneEdge) begin
                    acc_d       = acc_q + ACC_W'(adc_result_i);
                    sampleCnt_d = sampleCnt_q + 9'd1;
                    state_d     = ACC;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (tmoHit) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + TMO_W'(1);
                end
`endif
            end
            ACC: begin
                if (sampleCnt_q < sampleTarget) begin
                    state_d = START;
                end else begin
                    resData_d  = RES_W'(acc_q >> shamt);
                    resCh_d    = ch_q;
                    resValid_d = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    resValid_d = 1'b0;
                    advance    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A finished or abandoned channel moves on to the next enabled one
        if (advance) begin
            acc_d       = '0;
            sampleCnt_d = '0;
            if (nextFound) begin
                ch_d    = nextIdx;
                state_d = START;
            end else if (cont_q) begin
                ch_d    = firstLatched;
                state_d = START;
            end else begin
                state_d = IDLE;
            end
        end

        if (!enable_i) begin
            state_d     = IDLE;
            acc_d       = '0;
            sampleCnt_d = '0;
            resValid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            chMask_q    <= '0;
            osr_q       <= '0;
            cont_q      <= 1'b0;
            acc_q       <= '0;
            sampleCnt_q <= '0;
            resData_q   <= '0;
            resCh_q     <= '0;
            resValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            chMask_q    <= chMask_d;
            osr_q       <= osr_d;
            cont_q      <= cont_d;
            acc_q       <= acc_d;
            sampleCnt_q <= sampleCnt_d;
            resData_q   <= resData_d;
            resCh_q     <= resCh_d;
            resValid_q  <= resValid_d;
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            waitCnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            waitCnt_q <= waitCnt_d;
            err_q     <= err_d;
        end
    end
`endif

    assign adc_start_o  = (state_q == START);
    assign adc_ch_sel_o = ch_q;
    assign busy_o       = (state_q != IDLE);
    assign res_data_o   = resData_q;
    assign res_ch_o     = resCh_q;
    assign res_valid_o  = resValid_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl: randomized scoreboard bench for adc_seq_ctrl with a behavioural ADC and averaging model.
// Define ADC_SEQ_TIMEOUT_EN for both files to exercise the conversion-timeout path.
module tb_adc_seq_ctrl;

    localparam int NCH   = 4;
    localparam int RES_W = 16;
    localparam int TMO_W = 16;
    localparam int CW    = 2;

    typedef struct {
        int          ch;
        logic [15:0] val;
    } ConvEntry;

    typedef struct {
        int          ch;
        logic [15:0] data;
    } ResEntry;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             trig;
    logic             continuous;
    logic [NCH-1:0]   chMask;
    logic [2:0]       osrSel;
    logic [TMO_W-1:0] timeoutCycles;
    logic             adcStart;
    logic [CW-1:0]    adcChSel;
    logic [RES_W-1:0] adcResult;
    logic             adcDone;
    logic [RES_W-1:0] resData;
    logic [CW-1:0]    resCh;
    logic             resValid;
    logic             resReady;
    logic             busy;
    logic             errTimeout;

    ConvEntry    convQ[$];
    ResEntry     resQ[$];
    int          total      = 0;
    int          bad        = 0;
    int          startCount = 0;
    int          readyMode  = 0;
    bit          autoAdc    = 1'b1;
    logic [15:0] lastData   = '0;

    always #5 clk = ~clk;

    adc_seq_ctrl #(
        .NCH   (NCH),
        .RES_W (RES_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .trig_i           (trig),
        .continuous_i     (continuous),
        .ch_mask_i        (chMask),
        .osr_sel_i        (osrSel),
        .timeout_cycles_i (timeoutCycles),
        .adc_start_o      (adcStart),
        .adc_ch_sel_o     (adcChSel),
        .adc_result_i     (adcResult),
        .adc_done_i       (adcDone),
        .res_data_o       (resData),
        .res_ch_o         (resCh),
        .res_valid_o      (resValid),
        .res_ready_i      (resReady),
        .busy_o           (busy),
        .err_timeout_o    (errTimeout)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: every enabled channel in ascending order, mean of 4^min(osr,4) samples
    task automatic applyStimulus(input logic [3:0] mask, input int osr, input bit cont,
                                 input int nResIn, input int pattern);
        int          osrEff;
        int          n;
        int          made;
        int          ch;
        int          nRes;
        longint      sum;
        logic [15:0] v;
        osrEff = (osr > 4) ? 4 : osr;
        n = 1;
        repeat (osrEff) n = n * 4;
        nRes = nResIn;
        if (!cont) begin
            nRes = 0;
            for (int i = 0; i < NCH; i++) if (mask[i]) nRes++;
        end
        made = 0;
        ch   = 0;
        while (made < nRes) begin
            if (mask[ch]) begin
                sum = 0;
                for (int k = 0; k < n; k++) begin
                    case (pattern)
                        0:       v = 16'($urandom);
                        1:       v = 16'h3344;
                        default: v = (k % 2 == 0) ? 16'h1122 : 16'h3344;
                    endcase
                    convQ.push_back('{ch, v});
                    sum += longint'(v);
                end
                resQ.push_back('{ch, 16'(sum / n)});
                made++;
            end
            ch = (ch + 1) % NCH;
        end
        @(posedge clk); #1;
        chMask     = mask;
        osrSel     = 3'(osr);
        continuous = cont;
        trig       = 1'b1;
        @(posedge clk); #1;
        trig       = 1'b0;
        chMask     = 4'($urandom);
        osrSel     = 3'($urandom);
        continuous = 1'($urandom);
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((resQ.size() == 0) && !busy) && (n < maxCycles));
        checkOutput({tag, "_finished"}, 32'((resQ.size() == 0) && !busy), 32'd1);
        checkOutput({tag, "_conv_left"}, 32'(convQ.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Consumer backpressure: 0 = stall, 1 = always ready, other = random
    initial begin
        resReady = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0:       resReady = 1'b0;
                1:       resReady = 1'b1;
                default: resReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural ADC: answers each start after a random latency, checks the channel it was asked for
    initial begin
        ConvEntry    e;
        logic [15:0] v;
        int          lat;
        adcDone   = 1'b0;
        adcResult = '0;
        forever begin
            @(negedge clk);
            if (adcStart && autoAdc && !rst) begin
                if (convQ.size() > 0) begin
                    e = convQ.pop_front();
                    checkOutput("adc_ch_sel", 32'(adcChSel), 32'(e.ch));
                    v = e.val;
                end else begin
                    v = 16'($urandom);
                end
                lat = $urandom_range(3, 8);
                repeat (lat) @(posedge clk);
                #3;
                adcResult = v;
                adcDone   = 1'b1;
                repeat (2) @(posedge clk);
                #3;
                adcDone = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and polices the stream protocol
    initial begin
        ResEntry     r;
        logic        prevValid;
        logic        prevReady;
        logic        prevStart;
        logic [15:0] prevData;
        logic [1:0]  prevCh;
        prevValid = 1'b0;
        prevReady = 1'b0;
        prevStart = 1'b0;
        prevData  = '0;
        prevCh    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
                prevReady = 1'b0;
                prevStart = 1'b0;
            end else begin
                if (adcStart) startCount++;
                if (prevStart) checkOutput("start_one_cycle", 32'(adcStart), 32'd0);
                if (resValid) checkOutput("no_start_while_valid", 32'(adcStart), 32'd0);
                if (prevValid && prevReady) checkOutput("valid_drops_after_hs", 32'(resValid), 32'd0);
                if (resValid && prevValid && !prevReady) begin
                    checkOutput("stall_data_stable", 32'(resData), 32'(prevData));
                    checkOutput("stall_ch_stable", 32'(resCh), 32'(prevCh));
                end
                if (resValid && resReady) begin
                    if (resQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_result: got ch %0d data %0h, expected none", resCh, resData);
                    end else begin
                        r = resQ.pop_front();
                        checkOutput("res_ch", 32'(resCh), 32'(r.ch));
                        checkOutput("res_data", 32'(resData), 32'(r.data));
                        lastData = resData;
                    end
                end
                prevValid = resValid;
                prevReady = resReady;
                prevStart = adcStart;
                prevData  = resData;
                prevCh    = resCh;
            end
        end
    end

    initial begin
        int sc;
        int viol;
        int n;
        rst           = 1'b1;
        enable        = 1'b1;
        trig          = 1'b0;
        continuous    = 1'b0;
        chMask        = '0;
        osrSel        = '0;
        timeoutCycles = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_adc_start", 32'(adcStart), 32'd0);
        checkOutput("reset_ch_sel", 32'(adcChSel), 32'd0);
        checkOutput("reset_res_data", 32'(resData), 32'd0);
        checkOutput("reset_res_ch", 32'(resCh), 32'd0);
        checkOutput("reset_res_valid", 32'(resValid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(errTimeout), 32'd0);

        $display("[TB] two-channel scan, constant code");
        readyMode = 2;
        sc = startCount;
        applyStimulus(4'b0101, 0, 1'b0, 0, 1);
        waitIdle(500, "scan_0101");
        checkOutput("scan_0101_starts", 32'(startCount - sc), 32'd2);
        checkOutput("scan_0101_busy", 32'(busy), 32'd0);

        $display("[TB] osr=2 alternating codes, trig while busy");
        readyMode = 1;
        sc = startCount;
        applyStimulus(4'b0001, 2, 1'b0, 0, 2);
        repeat (20) @(posedge clk);
        #1 trig = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
        waitIdle(2000, "osr2");
        checkOutput("osr2_starts", 32'(startCount - sc), 32'd16);
        checkOutput("osr2_average", 32'(lastData), 32'h2233);

        $display("[TB] backpressure hold for 50 cycles");
        readyMode = 0;
        applyStimulus(4'b0011, 0, 1'b0, 0, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resValid && n < 200);
        checkOutput("bp_valid_seen", 32'(resValid), 32'd1);
        sc   = startCount;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (!resValid || adcStart) viol++;
        end
        checkOutput("bp_held", 32'(viol), 32'd0);
        checkOutput("bp_no_start", 32'(startCount - sc), 32'd0);
        readyMode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (startCount == sc && n < 20);
        checkOutput("bp_next_channel_started", 32'(startCount - sc), 32'd1);
        readyMode = 2;
        waitIdle(500, "bp");

        $display("[TB] continuous ch3, enable dropped in WAIT");
        applyStimulus(4'b1000, 1, 1'b1, 3, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resQ.size() != 0 && n < 1000);
        checkOutput("cont_results_drained", 32'(resQ.size()), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!adcStart && n < 200);
        checkOutput("cont_restarted", 32'(adcStart), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        checkOutput("cont_busy_in_wait", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("enable_low_busy", 32'(busy), 32'd0);
        checkOutput("enable_low_valid", 32'(resValid), 32'd0);
        repeat (20) @(posedge clk);
        convQ.delete();
        resQ.delete();
        #1 enable = 1'b1;

        $display("[TB] trig with empty mask");
        sc = startCount;
        @(posedge clk);
        #1 chMask = '0;
        trig = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("mask0_busy", 32'(busy), 32'd0);
        checkOutput("mask0_starts", 32'(startCount - sc), 32'd0);

        $display("[TB] randomized scans");
        for (int t = 0; t < 6; t++) begin
            readyMode = 2;
            applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 2), 1'b0, 0, 0);
            waitIdle(5000, "random");
        end

        $display("[TB] osr clamp (osr_sel=5)");
        sc = startCount;
        applyStimulus(4'b0100, 5, 1'b0, 0, 0);
        waitIdle(10000, "clamp");
        checkOutput("clamp_starts", 32'(startCount - sc), 32'd256);

        $display("[TB] reset during WAIT");
        autoAdc = 1'b0;
        @(posedge clk);
        #1 chMask = 4'b0001;
        osrSel     = '0;
        continuous = 1'b0;
        trig       = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #2 adcDone = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sc   = startCount;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (adcStart || resValid || busy) viol++;
        end
        checkOutput("rst_quiet", 32'(viol), 32'd0);
        checkOutput("rst_no_start", 32'(startCount - sc), 32'd0);
        checkOutput("rst_ch_sel", 32'(adcChSel), 32'd0);
        checkOutput("rst_res_data", 32'(resData), 32'd0);
        checkOutput("rst_res_ch", 32'(resCh), 32'd0);
        checkOutput("rst_err", 32'(errTimeout), 32'd0);
        adcDone = 1'b0;
        autoAdc = 1'b1;
        repeat (5) @(posedge clk);
        readyMode = 2;
        applyStimulus(4'b1010, 1, 1'b0, 0, 0);
        waitIdle(2000, "after_rst");

`ifdef ADC_SEQ_TIMEOUT_EN
        $display("[TB] conversion timeout");
        autoAdc       = 1'b0;
        timeoutCycles = 16'd100;
        @(posedge clk);
        #1 chMask = 4'b0001;
        osrSel     = '0;
        continuous = 1'b0;
        trig       = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
        @(negedge clk);
        checkOutput("tmo_start", 32'(adcStart), 32'd1);
        viol = 0;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            if (resValid) viol++;
            if (k == 100) begin
                checkOutput("tmo_err_before", 32'(errTimeout), 32'd0);
                checkOutput("tmo_busy_before", 32'(busy), 32'd1);
            end
            if (k == 101) begin
                checkOutput("tmo_err_set", 32'(errTimeout), 32'd1);
                checkOutput("tmo_busy_after", 32'(busy), 32'd0);
            end
        end
        checkOutput("tmo_no_result", 32'(viol), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("tmo_err_sticky", 32'(errTimeout), 32'd1);
        autoAdc = 1'b1;
        applyStimulus(4'b0001, 0, 1'b0, 0, 0);
        @(negedge clk);
        checkOutput("tmo_err_cleared_by_trig", 32'(errTimeout), 32'd0);
        waitIdle(500, "tmo_recover");
        timeoutCycles = '0;
`else
        checkOutput("err_tied_low", 32'(errTimeout), 32'd0);
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
